// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: datarw access codes, memory-stage FSM encoding
// and small decode helpers used by the memory access path.
package cpu_pkg;

  localparam logic [2:0] DRW_LB  = 3'b000;
  localparam logic [2:0] DRW_LH  = 3'b001;
  localparam logic [2:0] DRW_LBU = 3'b010;
  localparam logic [2:0] DRW_LHU = 3'b011;
  localparam logic [2:0] DRW_LW  = 3'b100;
  localparam logic [2:0] DRW_SB  = 3'b101;
  localparam logic [2:0] DRW_SH  = 3'b110;
  localparam logic [2:0] DRW_SW  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_FIN   = 2'd3
  } mau_state_t;

  // Access size in bytes (1, 2 or 4).
  function automatic logic [2:0] access_size(input logic [2:0] drw);
    case (drw)
      DRW_LB, DRW_LBU, DRW_SB: access_size = 3'd1;
      DRW_LH, DRW_LHU, DRW_SH: access_size = 3'd2;
      default:                 access_size = 3'd4;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] drw);
    is_store = (drw == DRW_SB) || (drw == DRW_SH) || (drw == DRW_SW);
  endfunction

  function automatic logic is_unsigned(input logic [2:0] drw);
    is_unsigned = (drw == DRW_LBU) || (drw == DRW_LHU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: shifts store data/enables into a two-word window
// and extracts/extends load data from a two-word read buffer. No state, no handshake.
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [2:0]  datarw,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [55:0] rbuf,
  output logic [63:0] wide_data,
  output logic [7:0]  wide_be,
  output logic [31:0] load_data,
  output logic        spans
);

  logic [2:0]  size;
  logic [31:0] wmask;
  logic [3:0]  be_base;
  logic [31:0] shifted;

  always_comb begin
    size = access_size(datarw);
    case (size)
      3'd1:    begin wmask = 32'h0000_00FF; be_base = 4'b0001; end
      3'd2:    begin wmask = 32'h0000_FFFF; be_base = 4'b0011; end
      default: begin wmask = 32'hFFFF_FFFF; be_base = 4'b1111; end
    endcase

    spans     = ({2'b00, off} + {1'b0, size}) > 4'd4;
    wide_data = {32'h0, wdata & wmask} << {off, 3'b000};
    wide_be   = {4'h0, be_base} << off;

    // The highest start lane is 3, so byte 7 of the window is never reached.
    case (off)
      2'd0:    shifted = rbuf[31:0];
      2'd1:    shifted = rbuf[39:8];
      2'd2:    shifted = rbuf[47:16];
      default: shifted = rbuf[55:24];
    endcase

    case (size)
      3'd1:    load_data = is_unsigned(datarw) ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
      3'd2:    load_data = is_unsigned(datarw) ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I memory stage: splits byte/half/word accesses into one or two word beats on a req/ack bus.
// Aligned access with immediate ack: start->done in 2 cycles; bus outputs hold until mem_ack.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  datarw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  mau_state_t  state, state_nxt;
  logic [2:0]  drw_q, drw_nxt;
  logic [1:0]  off_q, off_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [31:0] w0_q, w0_nxt;

  logic        busy_nxt, done_nxt, err_nxt, req_nxt, we_nxt;
  logic [3:0]  be_nxt;
  logic [31:0] addr_nxt, wd_nxt, rdata_nxt;

  logic [2:0]  sel_drw;
  logic [1:0]  sel_off;
  logic [31:0] sel_wdata;
  logic [55:0] rbuf;
  logic [63:0] wide_data;
  logic [7:0]  wide_be;
  logic [31:0] load_data;
  logic        spans;
  logic        ack;

  // In IDLE the aligner sees the incoming request so beat 0 can be registered at acceptance.
  assign sel_drw   = (state == ST_IDLE) ? datarw      : drw_q;
  assign sel_off   = (state == ST_IDLE) ? addr[1:0]   : off_q;
  assign sel_wdata = (state == ST_IDLE) ? wdata       : wdata_q;
  assign rbuf      = (state == ST_BEAT1) ? {mem_rdata[23:0], w0_q} : {24'h0, mem_rdata};
  assign ack       = mem_req && mem_ack;

  mem_lane_align u_align (
    .datarw    (sel_drw),
    .off       (sel_off),
    .wdata     (sel_wdata),
    .rbuf      (rbuf),
    .wide_data (wide_data),
    .wide_be   (wide_be),
    .load_data (load_data),
    .spans     (spans)
  );

  always_comb begin
    state_nxt = state;
    drw_nxt   = drw_q;
    off_nxt   = off_q;
    wdata_nxt = wdata_q;
    w0_nxt    = w0_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    be_nxt    = mem_be;
    addr_nxt  = mem_addr;
    wd_nxt    = mem_wdata;
    rdata_nxt = rdata;

    case (state)
      ST_IDLE: begin
        if (start) begin
          drw_nxt   = datarw;
          off_nxt   = addr[1:0];
          wdata_nxt = wdata;
          busy_nxt  = 1'b1;
          if (spans && !ALLOW_MISALIGNED) begin
            state_nxt = ST_FIN;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ST_BEAT0;
            req_nxt   = 1'b1;
            we_nxt    = is_store(datarw);
            be_nxt    = is_store(datarw) ? wide_be[3:0] : 4'hF;
            addr_nxt  = {addr[31:2], 2'b00};
            wd_nxt    = is_store(datarw) ? wide_data[31:0] : 32'h0;
          end
        end
      end
      ST_BEAT0: begin
        if (ack) begin
          w0_nxt = mem_rdata;
          if (spans) begin
            state_nxt = ST_BEAT1;
            addr_nxt  = mem_addr + 32'd4;
            be_nxt    = is_store(drw_q) ? wide_be[7:4] : 4'hF;
            wd_nxt    = is_store(drw_q) ? wide_data[63:32] : 32'h0;
          end else begin
            state_nxt = ST_FIN;
            req_nxt   = 1'b0;
            done_nxt  = 1'b1;
            if (!is_store(drw_q)) rdata_nxt = load_data;
          end
        end
      end
      ST_BEAT1: begin
        if (ack) begin
          state_nxt = ST_FIN;
          req_nxt   = 1'b0;
          done_nxt  = 1'b1;
          if (!is_store(drw_q)) rdata_nxt = load_data;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      drw_q     <= 3'h0;
      off_q     <= 2'h0;
      wdata_q   <= 32'h0;
      w0_q      <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rdata     <= 32'h0;
    end else begin
      state     <= state_nxt;
      drw_q     <= drw_nxt;
      off_q     <= off_nxt;
      wdata_q   <= wdata_nxt;
      w0_q      <= w0_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_be    <= be_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wd_nxt;
      rdata     <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: u0 allows split accesses, u1 rejects them.
module tb_mem_access_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [2:0]  datarw = 3'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0, mem_rdata = 32'h0;
  logic        ack0 = 1'b0, ack1 = 1'b0;

  logic        u0_busy, u0_done, u0_err, u0_req, u0_we;
  logic [3:0]  u0_be;
  logic [31:0] u0_rdata, u0_addr, u0_wdata;
  logic        u1_busy, u1_done, u1_err, u1_req, u1_we;
  logic [3:0]  u1_be;
  logic [31:0] u1_rdata, u1_addr, u1_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) u0 (
    .clk(clk), .reset(reset), .start(start0), .datarw(datarw), .addr(addr), .wdata(wdata),
    .busy(u0_busy), .done(u0_done), .err(u0_err), .rdata(u0_rdata),
    .mem_req(u0_req), .mem_we(u0_we), .mem_be(u0_be), .mem_addr(u0_addr), .mem_wdata(u0_wdata),
    .mem_ack(ack0), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .datarw(datarw), .addr(addr), .wdata(wdata),
    .busy(u1_busy), .done(u1_done), .err(u1_err), .rdata(u1_rdata),
    .mem_req(u1_req), .mem_we(u1_we), .mem_be(u1_be), .mem_addr(u1_addr), .mem_wdata(u1_wdata),
    .mem_ack(ack1), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [2:0] d, input logic [31:0] a, input logic [31:0] w, input bit which);
    datarw = d; addr = a; wdata = w;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    n_vec++; if ({u0_busy, u0_done, u0_err, u0_req, u0_we, u0_be, u0_addr, u0_wdata, u0_rdata} !== '0) begin n_err++; $display("FAIL reset_u0 got busy=%b done=%b req=%b be=%h addr=%h wd=%h rd=%h want all zero", u0_busy, u0_done, u0_req, u0_be, u0_addr, u0_wdata, u0_rdata); end
    n_vec++; if ({u1_busy, u1_done, u1_err, u1_req, u1_we, u1_be, u1_addr, u1_wdata, u1_rdata} !== '0) begin n_err++; $display("FAIL reset_u1 got busy=%b done=%b req=%b be=%h addr=%h wd=%h rd=%h want all zero", u1_busy, u1_done, u1_req, u1_be, u1_addr, u1_wdata, u1_rdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sw_aligned();
    ack0 = 1'b1;
    issue(DRW_SW, 32'h100, 32'hDEADBEEF, 1'b0);
    n_vec++; if ({u0_req, u0_we, u0_be, u0_busy, u0_done} !== {1'b1, 1'b1, 4'b1111, 1'b1, 1'b0}) begin n_err++; $display("FAIL sw_c1_ctl got req=%b we=%b be=%b busy=%b done=%b want 1 1 1111 1 0", u0_req, u0_we, u0_be, u0_busy, u0_done); end
    n_vec++; if ({u0_addr, u0_wdata} !== {32'h100, 32'hDEADBEEF}) begin n_err++; $display("FAIL sw_c1_bus got addr=%h wd=%h want 00000100 deadbeef", u0_addr, u0_wdata); end
    tick();
    n_vec++; if ({u0_done, u0_err, u0_req} !== 3'b100) begin n_err++; $display("FAIL sw_c2 got done=%b err=%b req=%b want 1 0 0", u0_done, u0_err, u0_req); end
    tick();
    n_vec++; if ({u0_done, u0_busy} !== 2'b00) begin n_err++; $display("FAIL sw_c3 got done=%b busy=%b want 0 0", u0_done, u0_busy); end
  endtask

  task automatic test_byte_loads();
    mem_rdata = 32'h80123456;
    issue(DRW_LB, 32'h203, 32'h0, 1'b0);
    n_vec++; if ({u0_req, u0_we, u0_be, u0_addr} !== {1'b1, 1'b0, 4'hF, 32'h200}) begin n_err++; $display("FAIL lb_c1 got req=%b we=%b be=%b addr=%h want 1 0 1111 00000200", u0_req, u0_we, u0_be, u0_addr); end
    tick();
    n_vec++; if ({u0_done, u0_rdata} !== {1'b1, 32'hFFFFFF80}) begin n_err++; $display("FAIL lb_rdata got done=%b rdata=%h want 1 ffffff80", u0_done, u0_rdata); end
    tick();
    n_vec++; if (u0_rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_hold got %h want ffffff80", u0_rdata); end
    issue(DRW_LBU, 32'h203, 32'h0, 1'b0);
    tick();
    n_vec++; if ({u0_done, u0_rdata} !== {1'b1, 32'h00000080}) begin n_err++; $display("FAIL lbu_rdata got done=%b rdata=%h want 1 00000080", u0_done, u0_rdata); end
    tick();
  endtask

  task automatic test_sh();
    issue(DRW_SH, 32'h302, 32'h1234ABCD, 1'b0);
    n_vec++; if ({u0_we, u0_be, u0_addr, u0_wdata} !== {1'b1, 4'b1100, 32'h300, 32'hABCD0000}) begin n_err++; $display("FAIL sh_bus got we=%b be=%b addr=%h wd=%h want 1 1100 00000300 abcd0000", u0_we, u0_be, u0_addr, u0_wdata); end
    tick();
    n_vec++; if ({u0_done, u0_req} !== 2'b10) begin n_err++; $display("FAIL sh_single got done=%b req=%b want 1 0", u0_done, u0_req); end
    tick();
  endtask

  task automatic test_split_load();
    issue(DRW_LW, 32'h401, 32'h0, 1'b0);
    mem_rdata = 32'h44332211;
    n_vec++; if ({u0_req, u0_be, u0_addr} !== {1'b1, 4'hF, 32'h400}) begin n_err++; $display("FAIL lw_split_b0 got req=%b be=%b addr=%h want 1 1111 00000400", u0_req, u0_be, u0_addr); end
    tick();
    mem_rdata = 32'h88776655;
    n_vec++; if ({u0_req, u0_done, u0_addr} !== {1'b1, 1'b0, 32'h404}) begin n_err++; $display("FAIL lw_split_b1 got req=%b done=%b addr=%h want 1 0 00000404", u0_req, u0_done, u0_addr); end
    tick();
    n_vec++; if ({u0_done, u0_rdata} !== {1'b1, 32'h55443322}) begin n_err++; $display("FAIL lw_split_rdata got done=%b rdata=%h want 1 55443322", u0_done, u0_rdata); end
    tick();
  endtask

  task automatic test_split_store_stall();
    ack0 = 1'b0;
    issue(DRW_SW, 32'h401, 32'hA1B2C3D4, 1'b0);
    n_vec++; if ({u0_req, u0_we, u0_be, u0_addr, u0_wdata} !== {1'b1, 1'b1, 4'b1110, 32'h400, 32'hB2C3D400}) begin n_err++; $display("FAIL sw_split_b0 got req=%b we=%b be=%b addr=%h wd=%h want 1 1 1110 00000400 b2c3d400", u0_req, u0_we, u0_be, u0_addr, u0_wdata); end
    tick();
    n_vec++; if ({u0_req, u0_be, u0_addr, u0_wdata} !== {1'b1, 4'b1110, 32'h400, 32'hB2C3D400}) begin n_err++; $display("FAIL sw_split_stable got req=%b be=%b addr=%h wd=%h want 1 1110 00000400 b2c3d400", u0_req, u0_be, u0_addr, u0_wdata); end
    ack0 = 1'b1;
    datarw = DRW_LW; addr = 32'h600; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n_vec++; if ({u0_req, u0_we, u0_be, u0_addr, u0_wdata} !== {1'b1, 1'b1, 4'b0001, 32'h404, 32'h000000A1}) begin n_err++; $display("FAIL sw_split_b1 got req=%b we=%b be=%b addr=%h wd=%h want 1 1 0001 00000404 000000a1", u0_req, u0_we, u0_be, u0_addr, u0_wdata); end
    tick();
    n_vec++; if ({u0_done, u0_req} !== 2'b10) begin n_err++; $display("FAIL sw_split_done got done=%b req=%b want 1 0", u0_done, u0_req); end
    tick();
    n_vec++; if ({u0_req, u0_busy, u0_done} !== 3'b000) begin n_err++; $display("FAIL start_while_busy got req=%b busy=%b done=%b want 0 0 0", u0_req, u0_busy, u0_done); end
  endtask

  task automatic test_addr_wrap();
    issue(DRW_LH, 32'hFFFFFFFF, 32'h0, 1'b0);
    mem_rdata = 32'h11223344;
    n_vec++; if (u0_addr !== 32'hFFFFFFFC) begin n_err++; $display("FAIL wrap_b0 got addr=%h want fffffffc", u0_addr); end
    tick();
    mem_rdata = 32'h000000AB;
    n_vec++; if ({u0_req, u0_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wrap_b1 got req=%b addr=%h want 1 00000000", u0_req, u0_addr); end
    tick();
    n_vec++; if ({u0_done, u0_rdata} !== {1'b1, 32'hFFFFAB11}) begin n_err++; $display("FAIL wrap_rdata got done=%b rdata=%h want 1 ffffab11", u0_done, u0_rdata); end
    tick();
  endtask

  task automatic test_misaligned_reject();
    ack1 = 1'b1;
    issue(DRW_LH, 32'h3, 32'h0, 1'b1);
    n_vec++; if ({u1_done, u1_err, u1_req} !== 3'b110) begin n_err++; $display("FAIL reject_c1 got done=%b err=%b req=%b want 1 1 0", u1_done, u1_err, u1_req); end
    tick();
    n_vec++; if ({u1_done, u1_err, u1_req} !== 3'b000) begin n_err++; $display("FAIL reject_c2 got done=%b err=%b req=%b want 0 0 0", u1_done, u1_err, u1_req); end
    mem_rdata = 32'hBEEF0000;
    issue(DRW_LHU, 32'h2, 32'h0, 1'b1);
    n_vec++; if ({u1_req, u1_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL edge_lhu_req got req=%b addr=%h want 1 00000000", u1_req, u1_addr); end
    tick();
    n_vec++; if ({u1_done, u1_err, u1_rdata} !== {1'b1, 1'b0, 32'h0000BEEF}) begin n_err++; $display("FAIL edge_lhu got done=%b err=%b rdata=%h want 1 0 0000beef", u1_done, u1_err, u1_rdata); end
    tick();
    issue(DRW_LH, 32'h2, 32'h0, 1'b1);
    tick();
    n_vec++; if ({u1_done, u1_rdata} !== {1'b1, 32'hFFFFBEEF}) begin n_err++; $display("FAIL edge_lh got done=%b rdata=%h want 1 ffffbeef", u1_done, u1_rdata); end
    tick();
  endtask

  task automatic test_reset_abort();
    ack0 = 1'b0;
    issue(DRW_LW, 32'h500, 32'h0, 1'b0);
    tick(); tick(); tick(); tick();
    n_vec++; if ({u0_req, u0_addr} !== {1'b1, 32'h500}) begin n_err++; $display("FAIL abort_wait got req=%b addr=%h want 1 00000500", u0_req, u0_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if ({u0_req, u0_busy, u0_done} !== 3'b000) begin n_err++; $display("FAIL abort_reset got req=%b busy=%b done=%b want 0 0 0", u0_req, u0_busy, u0_done); end
    ack0 = 1'b1;
    issue(DRW_SW, 32'h104, 32'h0BADF00D, 1'b0);
    n_vec++; if ({u0_req, u0_addr, u0_wdata} !== {1'b1, 32'h104, 32'h0BADF00D}) begin n_err++; $display("FAIL abort_restart got req=%b addr=%h wd=%h want 1 00000104 0badf00d", u0_req, u0_addr, u0_wdata); end
    tick();
    n_vec++; if (u0_done !== 1'b1) begin n_err++; $display("FAIL abort_restart_done got %b want 1", u0_done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_byte_loads();
    test_sh();
    test_split_load();
    test_split_store_stall();
    test_addr_wrap();
    test_misaligned_reject();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
